// File: rtl/neuron_feeder_if.sv
// Stream, weight-write and neuron-side signals of neuron_feeder.
// master = upstream/neuron side driving the feeder, slave = the feeder itself.
interface neuron_feeder_if #(
  parameter int SET_W = 2
) ();
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             w_wr_en;
  logic [SET_W+1:0] w_wr_addr;
  logic [15:0]      w_wr_data;
  logic             w_wr_drop;
  logic [15:0]      x1, x2, x3;
  logic [15:0]      w1, w2, w3;
  logic             done1, done2, done3;
  logic             neuron_done;
  logic [SET_W-1:0] set_idx;
  logic             busy;
  logic             vec_done;
  logic             err;

  modport master (
    output in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, neuron_done,
    input  in_ready, w_wr_drop, x1, x2, x3, w1, w2, w3, done1, done2, done3,
           set_idx, busy, vec_done, err
  );

  modport slave (
    input  in_valid, in_data, w_wr_en, w_wr_addr, w_wr_data, neuron_done,
    output in_ready, w_wr_drop, x1, x2, x3, w1, w2, w3, done1, done2, done3,
           set_idx, busy, vec_done, err
  );
endinterface

// File: rtl/neuron_feeder.sv
// Collects a 3-lane FP16 vector and issues it once per stored weight set to a single neuron.
// Optional WAIT timeout with sticky err: define NEURON_FEEDER_TIMEOUT_EN.
module neuron_feeder #(
  parameter int NUM_SETS    = 4,
  parameter int SET_W       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           reset,
  neuron_feeder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_ISSUE   = 3'd2,
    S_WAIT    = 3'd3,
    S_NEXT    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0][15:0]  vec_q, vec_d;
  logic [2:0][15:0]  x_q, x_d;
  logic [2:0][15:0]  w_q, w_d;
  logic              done_q, done_d;
  logic [SET_W-1:0]  set_idx_q, set_idx_d;
  logic              busy_q, busy_d;
  logic              vec_done_q, vec_done_d;
  logic              in_ready_q, in_ready_d;
  logic              w_wr_drop_q, w_wr_drop_d;
`ifdef NEURON_FEEDER_TIMEOUT_EN
  logic              err_q, err_d;
  logic [15:0]       tmo_q, tmo_d;
`endif

  // Bank is deliberately not reset: contents are only meaningful after software writes.
  logic [2:0][15:0]  bank_q [NUM_SETS];

  logic              accept_s;
  logic [SET_W-1:0]  wr_set_s;
  logic [1:0]        wr_lane_s;
  logic              wr_ok_s;

  // Weight-write address decode and acceptance
  always_comb begin
    wr_set_s    = bus.w_wr_addr[SET_W+1:2];
    wr_lane_s   = bus.w_wr_addr[1:0];
    wr_ok_s     = !busy_q && (wr_lane_s != 2'd3) &&
                  ({1'b0, wr_set_s} < (SET_W+1)'(NUM_SETS));
    w_wr_drop_d = bus.w_wr_en && !wr_ok_s;
  end

  // Weight bank storage
  always_ff @(posedge clk) begin
    if (bus.w_wr_en && wr_ok_s) begin
      bank_q[wr_set_s][wr_lane_s] <= bus.w_wr_data;
    end
  end

  // Next-state and output computation for the collect/issue sequencer
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    vec_d      = vec_q;
    x_d        = x_q;
    w_d        = w_q;
    done_d     = done_q;
    set_idx_d  = set_idx_q;
    busy_d     = busy_q;
    vec_done_d = 1'b0;
`ifdef NEURON_FEEDER_TIMEOUT_EN
    err_d      = err_q;
    tmo_d      = tmo_q;
`endif
    accept_s   = bus.in_valid && in_ready_q;

    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (accept_s) begin
          vec_d[lane_q] = bus.in_data;
          busy_d        = 1'b1;
          if (lane_q == 2'd2) begin
            lane_d  = 2'd0;
            state_d = S_ISSUE;
          end else begin
            lane_d  = lane_q + 2'd1;
            state_d = S_COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        x_d     = vec_q;
        w_d     = bank_q[set_idx_q];
        done_d  = 1'b1;
        state_d = S_WAIT;
`ifdef NEURON_FEEDER_TIMEOUT_EN
        tmo_d   = 16'd0;
`endif
      end
      S_WAIT: begin
        if (bus.neuron_done) begin
          done_d  = 1'b0;
          state_d = S_NEXT;
        end else begin
`ifdef NEURON_FEEDER_TIMEOUT_EN
          // Abandon the vector: no vec_done, the neuron is presumed hung.
          if (tmo_q == 16'(TIMEOUT_CYC - 1)) begin
            err_d     = 1'b1;
            done_d    = 1'b0;
            busy_d    = 1'b0;
            set_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_NEXT: begin
        if (set_idx_q == SET_W'(NUM_SETS - 1)) begin
          set_idx_d  = '0;
          vec_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          set_idx_d  = set_idx_q + SET_W'(1);
          state_d    = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
        lane_d  = 2'd0;
      end
    endcase

    in_ready_d = (state_d == S_IDLE) || (state_d == S_COLLECT);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'd0;
      vec_q       <= '0;
      x_q         <= '0;
      w_q         <= '0;
      done_q      <= 1'b0;
      set_idx_q   <= '0;
      busy_q      <= 1'b0;
      vec_done_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      w_wr_drop_q <= 1'b0;
`ifdef NEURON_FEEDER_TIMEOUT_EN
      err_q       <= 1'b0;
      tmo_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      vec_q       <= vec_d;
      x_q         <= x_d;
      w_q         <= w_d;
      done_q      <= done_d;
      set_idx_q   <= set_idx_d;
      busy_q      <= busy_d;
      vec_done_q  <= vec_done_d;
      in_ready_q  <= in_ready_d;
      w_wr_drop_q <= w_wr_drop_d;
`ifdef NEURON_FEEDER_TIMEOUT_EN
      err_q       <= err_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.w_wr_drop = w_wr_drop_q;
  assign bus.x1        = x_q[0];
  assign bus.x2        = x_q[1];
  assign bus.x3        = x_q[2];
  assign bus.w1        = w_q[0];
  assign bus.w2        = w_q[1];
  assign bus.w3        = w_q[2];
  assign bus.done1     = done_q;
  assign bus.done2     = done_q;
  assign bus.done3     = done_q;
  assign bus.set_idx   = set_idx_q;
  assign bus.busy      = busy_q;
  assign bus.vec_done  = vec_done_q;
`ifdef NEURON_FEEDER_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
